taxi_episode_ctrl: RTL and testbench

Episode controller that sits directly upstream of `TaxiStep`. It owns the registered Taxi environment state and draws a pseudo-random initial state per episode. It accepts agent actions over a valid/ready handshake, drives one `TaxiStep` evaluation per action, and returns the resulting observation downstream. It also tracks step count, truncation and episode return.

---
 rtl/taxi_pkg.sv | 48 ++++
 rtl/taxi_lfsr.sv | 32 +++
 rtl/taxi_episode_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_taxi_episode_ctrl.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_pkg.sv
// Shared Taxi definitions: action and reward codes, grid constants, controller
// state encoding and the signed reward decode.
package taxi_pkg;

  localparam int GRID_N   = 5;
  localparam int NUM_LOCS = 4;
  localparam logic [2:0] PASS_IN_TAXI = 3'd4;

  typedef enum logic [2:0] {
    ACT_SOUTH   = 3'd0,
    ACT_NORTH   = 3'd1,
    ACT_EAST    = 3'd2,
    ACT_WEST    = 3'd3,
    ACT_PICKUP  = 3'd4,
    ACT_DROPOFF = 3'd5
  } taxi_act_e;

  localparam logic [2:0] ACT_LAST = 3'd5;

  typedef enum logic [1:0] {
    RWD_STEP    = 2'd0,
    RWD_ILLEGAL = 2'd1,
    RWD_DROPOFF = 2'd2,
    RWD_RSVD    = 2'd3
  } taxi_rwd_e;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_RST_OBS = 3'd1,
    ST_READY   = 3'd2,
    ST_STEP    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_OBS     = 3'd5
  } ep_state_e;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic signed [11:0] reward_decode(input logic [1:0] code);
    case (code)
      RWD_STEP:    reward_decode = -12'sd1;
      RWD_ILLEGAL: reward_decode = -12'sd10;
      RWD_DROPOFF: reward_decode = 12'sd20;
      default:     reward_decode = 12'sd0;
    endcase
  endfunction

endpackage

// File: rtl/taxi_lfsr.sv
// 16-bit right-shifting Galois LFSR; advances only while en is high.
module taxi_lfsr
  import taxi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic [15:0] w_next;

  always_comb begin
    w_next = {1'b0, r_q[15:1]};
    if (r_q[0]) begin
      w_next = w_next ^ LFSR_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= seed;
    end else if (en) begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/taxi_episode_ctrl.sv
// Episode controller in front of TaxiStep: draws initial states, runs one
// TaxiStep evaluation per accepted action and presents the resulting observation.
module taxi_episode_ctrl
  import taxi_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 200,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ep_start,
  input  logic               act_valid,
  output logic               act_ready,
  input  logic [2:0]         act,
  output logic               act_err,
  output logic [2:0]         step_action,
  output logic [2:0]         step_taxi_row,
  output logic [2:0]         step_taxi_col,
  output logic [2:0]         step_pass_idx,
  output logic [1:0]         step_dest_idx,
  input  logic [2:0]         step_taxi_row_in,
  input  logic [2:0]         step_taxi_col_in,
  input  logic [2:0]         step_pass_idx_in,
  input  logic [1:0]         step_dest_idx_in,
  input  logic [1:0]         step_reward,
  input  logic               step_terminated,
  output logic               obs_valid,
  input  logic               obs_ready,
  output logic [2:0]         obs_row,
  output logic [2:0]         obs_col,
  output logic [2:0]         obs_pass,
  output logic [1:0]         obs_dest,
  output logic [1:0]         obs_reward,
  output logic               obs_terminated,
  output logic               obs_truncated,
  output logic               obs_is_reset,
  output logic signed [11:0] ep_return,
  output logic [7:0]         step_count,
  output logic [2:0]         dbg_state
);

  // Handshakes (act and obs): a transfer occurs on a rising clk edge where valid
  // and ready are both high; valid never waits on ready, and the payload is held
  // stable by its producer until the transfer edge.

  localparam logic [15:0] SEED_EFF    = (LFSR_SEED == 16'h0000) ? LFSR_DEFAULT_SEED : LFSR_SEED;
  localparam logic [7:0]  MAX_STEPS_B = 8'(MAX_STEPS);

  ep_state_e r_state;
  ep_state_e w_state_nxt;

  logic [2:0]         r_row;
  logic [2:0]         r_col;
  logic [2:0]         r_pass;
  logic [1:0]         r_dest;
  logic [2:0]         r_action;
  logic [1:0]         r_reward;
  logic               r_term;
  logic               r_trunc;
  logic               r_is_reset;
  logic               r_act_err;
  logic [7:0]         r_step_count;
  logic signed [11:0] r_ep_return;

  logic [15:0] w_lfsr_q;
  logic        w_lfsr_en;
  logic [2:0]  w_cand_row;
  logic [2:0]  w_cand_col;
  logic [2:0]  w_cand_pass;
  logic [1:0]  w_cand_dest;
  logic        w_cand_ok;
  logic        w_act_fire;
  logic        w_act_legal;
  logic [7:0]  w_count_inc;
  logic        w_unused_lfsr;

  assign w_lfsr_en = (r_state == ST_INIT);

  taxi_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (w_lfsr_en),
    .seed  (SEED_EFF),
    .q     (w_lfsr_q)
  );

  // Rejection sampling: a candidate is usable only if it lands on the grid and
  // the passenger does not already start at the destination.
  assign w_cand_row    = w_lfsr_q[2:0];
  assign w_cand_col    = w_lfsr_q[5:3];
  assign w_cand_pass   = {1'b0, w_lfsr_q[7:6]};
  assign w_cand_dest   = w_lfsr_q[9:8];
  assign w_cand_ok     = (w_cand_row < 3'(GRID_N)) && (w_cand_col < 3'(GRID_N)) &&
                         (w_lfsr_q[7:6] != w_lfsr_q[9:8]);
  assign w_unused_lfsr = ^w_lfsr_q[15:10];

  assign w_act_fire  = (r_state == ST_READY) && !ep_start && act_valid;
  assign w_act_legal = (act <= ACT_LAST);
  assign w_count_inc = r_step_count + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:    if (w_cand_ok) w_state_nxt = ST_RST_OBS;
      ST_RST_OBS: if (obs_ready) w_state_nxt = ST_READY;
      ST_READY: begin
        if (ep_start) begin
          w_state_nxt = ST_INIT;
        end else if (act_valid && w_act_legal) begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_STEP:    w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_OBS;
      ST_OBS: begin
        if (obs_ready) begin
          w_state_nxt = (r_term || r_trunc) ? ST_INIT : ST_READY;
        end
      end
      default:    w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    act_ready = 1'b0;
    obs_valid = 1'b0;
    case (r_state)
      ST_READY:           act_ready = !ep_start;
      ST_RST_OBS, ST_OBS: obs_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row        <= '0;
      r_col        <= '0;
      r_pass       <= '0;
      r_dest       <= '0;
      r_action     <= '0;
      r_reward     <= '0;
      r_term       <= 1'b0;
      r_trunc      <= 1'b0;
      r_is_reset   <= 1'b0;
      r_act_err    <= 1'b0;
      r_step_count <= '0;
      r_ep_return  <= '0;
    end else begin
      r_act_err <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (w_cand_ok) begin
            r_row        <= w_cand_row;
            r_col        <= w_cand_col;
            r_pass       <= w_cand_pass;
            r_dest       <= w_cand_dest;
            r_reward     <= '0;
            r_term       <= 1'b0;
            r_trunc      <= 1'b0;
            r_is_reset   <= 1'b1;
            r_step_count <= '0;
            r_ep_return  <= '0;
          end
        end
        ST_READY: begin
          if (w_act_fire) begin
            if (w_act_legal) begin
              r_action <= act;
            end else begin
              r_act_err <= 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          r_row        <= step_taxi_row_in;
          r_col        <= step_taxi_col_in;
          r_pass       <= step_pass_idx_in;
          r_dest       <= step_dest_idx_in;
          r_reward     <= step_reward;
          r_term       <= step_terminated;
          r_trunc      <= (w_count_inc == MAX_STEPS_B) && !step_terminated;
          r_is_reset   <= 1'b0;
          r_step_count <= w_count_inc;
          r_ep_return  <= r_ep_return + reward_decode(step_reward);
        end
        default: ;
      endcase
    end
  end

  assign act_err        = r_act_err;
  assign step_action    = r_action;
  assign step_taxi_row  = r_row;
  assign step_taxi_col  = r_col;
  assign step_pass_idx  = r_pass;
  assign step_dest_idx  = r_dest;
  assign obs_row        = r_row;
  assign obs_col        = r_col;
  assign obs_pass       = r_pass;
  assign obs_dest       = r_dest;
  assign obs_reward     = r_reward;
  assign obs_terminated = r_term;
  assign obs_truncated  = r_trunc;
  assign obs_is_reset   = r_is_reset;
  assign ep_return      = r_ep_return;
  assign step_count     = r_step_count;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_taxi_episode_ctrl.sv
// Bench for taxi_episode_ctrl: two instances (default, and MAX_STEPS=3 with a
// chosen seed) each in front of a behavioural TaxiStep stand-in.
`timescale 1ns/1ps
module tb_taxi_episode_ctrl;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] pass;
    logic [1:0] dest;
    logic [1:0] rew;
    logic       term;
  } env_t;

  typedef struct {
    logic [2:0] act;
    int row;
    int col;
    int pass;
    int rew;
    int term;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       ep_start;
  logic       act_valid;
  logic [2:0] act;
  logic       obs_ready;
  bit         ovr_term;
  int         sel;

  logic               a_act_ready [2];
  logic               a_act_err [2];
  logic               a_obs_valid [2];
  logic [2:0]         a_obs_row [2];
  logic [2:0]         a_obs_col [2];
  logic [2:0]         a_obs_pass [2];
  logic [1:0]         a_obs_dest [2];
  logic [1:0]         a_obs_reward [2];
  logic               a_obs_term [2];
  logic               a_obs_trunc [2];
  logic               a_obs_is_reset [2];
  logic signed [11:0] a_ep_return [2];
  logic [7:0]         a_step_count [2];
  logic [2:0]         a_step_action [2];
  logic [2:0]         a_step_row [2];
  logic [2:0]         a_step_col [2];
  logic [2:0]         a_step_pass [2];
  logic [1:0]         a_step_dest [2];
  logic [2:0]         a_dbg_state [2];

  int checks = 0;
  int errors = 0;

  env_t        m_st [2];
  int          m_cnt [2];
  int          m_ret [2];
  bit          m_trunc [2];
  bit          m_done [2];
  logic [15:0] m_lfsr [2];
  int          max_steps [2] = '{200, 3};

  function automatic int loc_at(input int r, input int c);
    if (r == 0 && c == 0) return 0;
    if (r == 0 && c == 4) return 1;
    if (r == 4 && c == 0) return 2;
    if (r == 4 && c == 3) return 3;
    return -1;
  endfunction

  // Open 5x5 grid, no walls; pickup/dropoff legality from the four landmarks.
  function automatic env_t env_step(input env_t s, input int a, input bit ft);
    env_t r;
    int   here;
    r      = s;
    r.rew  = 2'd0;
    r.term = 1'b0;
    here   = loc_at(int'(s.row), int'(s.col));
    case (a)
      0: if (s.row < 3'd4) r.row = s.row + 3'd1;
      1: if (s.row > 3'd0) r.row = s.row - 3'd1;
      2: if (s.col < 3'd4) r.col = s.col + 3'd1;
      3: if (s.col > 3'd0) r.col = s.col - 3'd1;
      4: begin
        if (s.pass < 3'd4 && here == int'(s.pass)) r.pass = 3'd4;
        else r.rew = 2'd1;
      end
      5: begin
        if (s.pass == 3'd4 && here == int'(s.dest)) begin
          r.pass = {1'b0, s.dest};
          r.rew  = 2'd2;
          r.term = 1'b1;
        end else begin
          r.rew = 2'd1;
        end
      end
      default: r.rew = 2'd3;
    endcase
    if (ft) begin
      r.rew  = 2'd2;
      r.term = 1'b1;
    end
    return r;
  endfunction

  function automatic int rdec(input logic [1:0] c);
    case (c)
      2'd0:    return -1;
      2'd1:    return -10;
      2'd2:    return 20;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    env_t stub_q;
    env_t stub_in;
    assign stub_in = {a_step_row[g], a_step_col[g], a_step_pass[g], a_step_dest[g], 2'd0, 1'b0};
    always @(posedge clk) stub_q <= env_step(stub_in, int'(a_step_action[g]), ovr_term);

    taxi_episode_ctrl #(
      .MAX_STEPS (g == 0 ? 200 : 3),
      .LFSR_SEED (g == 0 ? 16'hACE1 : 16'h0382)
    ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .ep_start         (ep_start && (sel == g)),
      .act_valid        (act_valid && (sel == g)),
      .act_ready        (a_act_ready[g]),
      .act              (act),
      .act_err          (a_act_err[g]),
      .step_action      (a_step_action[g]),
      .step_taxi_row    (a_step_row[g]),
      .step_taxi_col    (a_step_col[g]),
      .step_pass_idx    (a_step_pass[g]),
      .step_dest_idx    (a_step_dest[g]),
      .step_taxi_row_in (stub_q.row),
      .step_taxi_col_in (stub_q.col),
      .step_pass_idx_in (stub_q.pass),
      .step_dest_idx_in (stub_q.dest),
      .step_reward      (stub_q.rew),
      .step_terminated  (stub_q.term),
      .obs_valid        (a_obs_valid[g]),
      .obs_ready        (obs_ready && (sel == g)),
      .obs_row          (a_obs_row[g]),
      .obs_col          (a_obs_col[g]),
      .obs_pass         (a_obs_pass[g]),
      .obs_dest         (a_obs_dest[g]),
      .obs_reward       (a_obs_reward[g]),
      .obs_terminated   (a_obs_term[g]),
      .obs_truncated    (a_obs_trunc[g]),
      .obs_is_reset     (a_obs_is_reset[g]),
      .ep_return        (a_ep_return[g]),
      .step_count       (a_step_count[g]),
      .dbg_state        (a_dbg_state[g])
    );
  end

  task automatic chk(input string tag, input string fld, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s.%s: got %0d want %0d", tag, fld, got, want);
    end
  endtask

  task automatic check_idle(input string tag);
    chk(tag, "act_ready", a_act_ready[sel], 0);
    chk(tag, "act_err", a_act_err[sel], 0);
    chk(tag, "obs_valid", a_obs_valid[sel], 0);
    chk(tag, "obs_row", a_obs_row[sel], 0);
    chk(tag, "obs_col", a_obs_col[sel], 0);
    chk(tag, "obs_pass", a_obs_pass[sel], 0);
    chk(tag, "obs_dest", a_obs_dest[sel], 0);
    chk(tag, "obs_reward", a_obs_reward[sel], 0);
    chk(tag, "obs_term", a_obs_term[sel], 0);
    chk(tag, "obs_trunc", a_obs_trunc[sel], 0);
    chk(tag, "obs_is_reset", a_obs_is_reset[sel], 0);
    chk(tag, "step_action", a_step_action[sel], 0);
    chk(tag, "step_row", a_step_row[sel], 0);
    chk(tag, "step_col", a_step_col[sel], 0);
    chk(tag, "step_pass", a_step_pass[sel], 0);
    chk(tag, "step_dest", a_step_dest[sel], 0);
    chk(tag, "step_count", a_step_count[sel], 0);
    chk(tag, "ep_return", int'(a_ep_return[sel]), 0);
  endtask

  task automatic check_obs(input string tag, input int exp_reset);
    chk(tag, "obs_valid", a_obs_valid[sel], 1);
    chk(tag, "act_ready", a_act_ready[sel], 0);
    chk(tag, "row", a_obs_row[sel], m_st[sel].row);
    chk(tag, "col", a_obs_col[sel], m_st[sel].col);
    chk(tag, "pass", a_obs_pass[sel], m_st[sel].pass);
    chk(tag, "dest", a_obs_dest[sel], m_st[sel].dest);
    chk(tag, "reward", a_obs_reward[sel], m_st[sel].rew);
    chk(tag, "terminated", a_obs_term[sel], m_st[sel].term);
    chk(tag, "truncated", a_obs_trunc[sel], m_trunc[sel]);
    chk(tag, "is_reset", a_obs_is_reset[sel], exp_reset);
    chk(tag, "ep_return", int'(a_ep_return[sel]), m_ret[sel]);
    chk(tag, "step_count", a_step_count[sel], m_cnt[sel]);
  endtask

  task automatic model_draw(input int k);
    logic [15:0] v;
    for (int n = 0; n < 1000; n++) begin
      v = m_lfsr[k];
      m_lfsr[k] = lfsr_next(v);
      if (v[2:0] < 3'd5 && v[5:3] < 3'd5 && v[7:6] != v[9:8]) begin
        m_st[k] = '{row: v[2:0], col: v[5:3], pass: {1'b0, v[7:6]}, dest: v[9:8],
                    rew: 2'd0, term: 1'b0};
        m_cnt[k]   = 0;
        m_ret[k]   = 0;
        m_trunc[k] = 1'b0;
        m_done[k]  = 1'b0;
        return;
      end
    end
  endtask

  task automatic consume();
    obs_ready = 1'b1;
    @(negedge clk);
    obs_ready = 1'b0;
  endtask

  task automatic expect_reset_obs(input string tag);
    int n;
    model_draw(sel);
    n = 0;
    while (!a_obs_valid[sel] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!a_obs_valid[sel]) begin
      chk(tag, "reset_obs_timeout", 0, 1);
      return;
    end
    check_obs(tag, 1);
    consume();
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!a_act_ready[sel] && n < 32) begin
      @(negedge clk);
      n++;
    end
    chk(tag, "act_ready_wait", a_act_ready[sel], 1);
  endtask

  // Offers one action; for legal codes leaves the DUT presenting its observation.
  task automatic step_issue(input logic [2:0] a, input bit ft, input string tag);
    env_t r;
    wait_ready(tag);
    if (!a_act_ready[sel]) return;
    ovr_term  = ft;
    act       = a;
    act_valid = 1'b1;
    @(negedge clk);
    act_valid = 1'b0;
    if (a > 3'd5) begin
      chk(tag, "act_err_pulse", a_act_err[sel], 1);
      chk(tag, "err_count", a_step_count[sel], m_cnt[sel]);
      chk(tag, "err_row", a_obs_row[sel], m_st[sel].row);
      chk(tag, "err_col", a_obs_col[sel], m_st[sel].col);
      @(negedge clk);
      chk(tag, "act_err_clear", a_act_err[sel], 0);
      chk(tag, "err_ready", a_act_ready[sel], 1);
      chk(tag, "err_no_obs", a_obs_valid[sel], 0);
      return;
    end
    r = env_step(m_st[sel], int'(a), ft);
    m_cnt[sel]++;
    m_ret[sel]  += rdec(r.rew);
    m_trunc[sel] = (m_cnt[sel] == max_steps[sel]) && !r.term;
    m_done[sel]  = r.term || m_trunc[sel];
    m_st[sel]    = r;
    chk(tag, "lat1_obs_valid", a_obs_valid[sel], 0);
    @(negedge clk);
    chk(tag, "lat2_obs_valid", a_obs_valid[sel], 0);
    @(negedge clk);
    check_obs(tag, 0);
  endtask

  task automatic step_finish(input string tag);
    consume();
    ovr_term = 1'b0;
    if (m_done[sel]) expect_reset_obs({tag, "_next"});
  endtask

  task automatic do_step(input logic [2:0] a, input string tag, input int stall);
    step_issue(a, 1'b0, tag);
    if (a <= 3'd5) begin
      repeat (stall) begin
        @(negedge clk);
        check_obs(tag, 0);
      end
      step_finish(tag);
    end
  endtask

  task automatic do_ep_start(input string tag);
    wait_ready(tag);
    ep_start  = 1'b1;
    act_valid = 1'b1;
    act       = 3'd0;
    #1;
    chk(tag, "ready_low_on_start", a_act_ready[sel], 0);
    @(negedge clk);
    ep_start  = 1'b0;
    act_valid = 1'b0;
    expect_reset_obs(tag);
    chk(tag, "start_return", int'(a_ep_return[sel]), 0);
  endtask

  vec_t tbl [14];

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int exp_ret;
    int stall;
    tbl[0]  = '{3'd4, 1, 4, 3, 1, 0};
    tbl[1]  = '{3'd0, 2, 4, 3, 0, 0};
    tbl[2]  = '{3'd0, 3, 4, 3, 0, 0};
    tbl[3]  = '{3'd0, 4, 4, 3, 0, 0};
    tbl[4]  = '{3'd3, 4, 3, 3, 0, 0};
    tbl[5]  = '{3'd4, 4, 3, 4, 0, 0};
    tbl[6]  = '{3'd1, 3, 3, 4, 0, 0};
    tbl[7]  = '{3'd1, 2, 3, 4, 0, 0};
    tbl[8]  = '{3'd1, 1, 3, 4, 0, 0};
    tbl[9]  = '{3'd1, 0, 3, 4, 0, 0};
    tbl[10] = '{3'd3, 0, 2, 4, 0, 0};
    tbl[11] = '{3'd3, 0, 1, 4, 0, 0};
    tbl[12] = '{3'd3, 0, 0, 4, 0, 0};
    tbl[13] = '{3'd5, 0, 0, 0, 2, 1};

    reset = 1'b1; ep_start = 1'b0; act_valid = 1'b0; act = 3'd0;
    obs_ready = 1'b0; ovr_term = 1'b0; sel = 0;
    m_lfsr[0] = 16'hACE1;
    m_lfsr[1] = 16'h0382;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k;
      check_idle("reset");
    end
    reset = 1'b0;

    sel = 0;
    expect_reset_obs("first_obs");
    chk("first_obs", "const_row", a_obs_row[0], 1);
    chk("first_obs", "const_col", a_obs_col[0], 4);
    chk("first_obs", "const_pass", a_obs_pass[0], 3);
    chk("first_obs", "const_dest", a_obs_dest[0], 0);

    do_step(3'd7, "act7", 0);

    exp_ret = 0;
    for (int i = 0; i < 14; i++) begin
      exp_ret += rdec(tbl[i].rew[1:0]);
      stall = (i == 2) ? 10 : 0;
      step_issue(tbl[i].act, 1'b0, "tbl");
      chk("tbl", "vec_row", a_obs_row[0], tbl[i].row);
      chk("tbl", "vec_col", a_obs_col[0], tbl[i].col);
      chk("tbl", "vec_pass", a_obs_pass[0], tbl[i].pass);
      chk("tbl", "vec_reward", a_obs_reward[0], tbl[i].rew);
      chk("tbl", "vec_term", a_obs_term[0], tbl[i].term);
      chk("tbl", "vec_count", a_step_count[0], i + 1);
      chk("tbl", "vec_return", int'(a_ep_return[0]), exp_ret);
      repeat (stall) begin
        @(negedge clk);
        check_obs("tbl_stall", 0);
      end
      step_finish("tbl");
    end
    chk("tbl", "final_return", exp_ret, -2);

    do_ep_start("ep_start");

    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6) do_ep_start("rnd_start");
      else if (r < 18) do_step(3'($urandom_range(6, 7)), "rnd_err", 0);
      else do_step(3'($urandom_range(0, 5)), "rnd", $urandom_range(0, 3));
    end

    sel = 1;
    expect_reset_obs("seed382");
    chk("seed382", "const_row", a_obs_row[1], 2);
    chk("seed382", "const_col", a_obs_col[1], 0);
    chk("seed382", "const_pass", a_obs_pass[1], 2);
    chk("seed382", "const_dest", a_obs_dest[1], 3);
    step_issue(3'd1, 1'b0, "north");
    chk("north", "const_row", a_obs_row[1], 1);
    chk("north", "const_reward", a_obs_reward[1], 0);
    chk("north", "const_return", int'(a_ep_return[1]), -1);
    chk("north", "const_count", a_step_count[1], 1);
    step_finish("north");
    do_step(3'($urandom_range(0, 3)), "mv2", 0);
    step_issue(3'($urandom_range(0, 3)), 1'b0, "trunc3");
    chk("trunc3", "const_trunc", a_obs_trunc[1], 1);
    chk("trunc3", "const_term", a_obs_term[1], 0);
    step_finish("trunc3");
    do_step(3'($urandom_range(0, 3)), "mv1b", 0);
    do_step(3'($urandom_range(0, 3)), "mv2b", 0);
    step_issue(3'($urandom_range(0, 3)), 1'b1, "term3");
    chk("term3", "const_term", a_obs_term[1], 1);
    chk("term3", "const_trunc", a_obs_trunc[1], 0);
    chk("term3", "const_reward", a_obs_reward[1], 2);
    step_finish("term3");

    sel = 0;
    wait_ready("midrst");
    act = 3'd0;
    act_valid = 1'b1;
    @(negedge clk);
    act_valid = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("midrst");
    reset = 1'b0;
    m_lfsr[0] = 16'hACE1;
    m_lfsr[1] = 16'h0382;
    expect_reset_obs("post_rst");
    chk("post_rst", "const_row", a_obs_row[0], 1);
    chk("post_rst", "const_col", a_obs_col[0], 4);
    chk("post_rst", "const_pass", a_obs_pass[0], 3);
    chk("post_rst", "const_dest", a_obs_dest[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
